mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Two-port arbiter sharing one external memory controller (PSRAM/SDRAM side) between a CPU-side requester (port A, fed by the CPU memory window) and a DMA requester (port B, fed by the PI DMA path).
- Serialises accesses with a req/ack handshake and alternates grants on contention.
- Returns read data to the granted port.
- Applies a watchdog timeout so a hung memory cannot lock the CPU bus.

Parameters:
- ADDR_W, 23, address width of all ports.
- DATA_W, 16, data width of all ports.
- TOUT, 255, cycles to wait for m_ack before forcing completion (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- a_req  in  1  port A request, level, held until a_ack
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_W  port A address
- a_dati  in  DATA_W  port A write data
- a_ack  out  1  port A completion, 1-cycle pulse
- a_dato  out  DATA_W  port A read data, valid with a_ack and held until next A completion
- b_req, b_we, b_addr, b_dati, b_ack, b_dato: same as port A, for port B
- m_req  out  1  memory request, level, held until m_ack or timeout
- m_we  out  1  memory write strobe qualifier
- m_addr  out  ADDR_W  memory address
- m_dati  out  DATA_W  memory write data
- m_dato  in  DATA_W  memory read data, valid when m_ack=1
- m_ack  in  1  memory completion, 1-cycle pulse
- grant  out  2  bit0 = A owns memory, bit1 = B owns memory (never both)
- tout_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at posedge): state IDLE.
  - All outputs 0: m_req, m_we, m_addr, m_dati, a_ack, b_ack, a_dato, b_dato, grant, tout_err.
  - last_b=1, so A wins the first contention.
  - Timeout counter 0.
  - Reset mid-transaction aborts it with no ack to either port. An m_ack arriving later is ignored.
- FSM states: IDLE, GNT_A, GNT_B, DONE.
- IDLE:
  - a_req only -> GNT_A.
  - b_req only -> GNT_B.
  - Both requesting -> the port not served last (A if last_b=1, else B).
  - On the transition edge, register m_addr/m_we/m_dati from the winner, set m_req=1 and set the grant bit.
  - Latency: request sampled at cycle N gives m_req=1 at N+1.
- GNT_x:
  - Hold m_req and the latched address/data stable. Requester inputs are not re-sampled.
  - On m_ack=1: drop m_req and grant next cycle. Register x_dato <= m_dato when m_we=0; leave x_dato unchanged on writes. Pulse x_ack for exactly one cycle. Set last_b = (x==B). Go to DONE.
  - Ack latency: m_ack at cycle M gives x_ack=1 at M+1.
- Timeout:
  - Counter increments each cycle in GNT_x and clears on entry.
  - When it reaches TOUT with no m_ack: drop m_req, pulse x_ack, set x_dato=all ones (reads only), set tout_err=1, go to DONE.
  - tout_err clears only on rst.
  - An m_ack in the same cycle as the timeout wins: normal completion, no error.
- DONE: one-cycle gap so the requester can deassert req. Always goes to IDLE and never grants in this cycle.
  - A port still requesting after that gap is treated as a new request.
- Requester drops req before ack: the transaction still completes and the ack pulse is still issued.
- m_ack while in IDLE or DONE: ignored.
- Widths: no address arithmetic; the counter is 16-bit and saturates at TOUT.

Test Plan:
- Single read A: a_req=1, a_addr=0x000123; memory acks 3 cycles after m_req with m_dato=0xBEEF -> m_req 1 cycle after a_req, m_addr=0x000123, grant=01, a_ack pulse 1 cycle after m_ack, a_dato=0xBEEF, b_ack never asserted.
- Contention: a_req and b_req both 1 from reset, each re-requesting immediately after its ack -> grant order A,B,A,B; each transaction separated by one DONE cycle with m_req=0.
- Write B: b_we=1, b_addr=0x7FFFFF, b_dati=0x55AA -> m_we=1, m_addr=0x7FFFFF, m_dati=0x55AA held stable until m_ack; b_dato unchanged.
- Timeout: TOUT=8, A read, m_ack never asserted -> m_req falls after 8 grant cycles, a_ack pulses, a_dato=0xFFFF, tout_err=1 and stays 1; next B transaction completes normally.
- Ack on timeout cycle: TOUT=8 with m_ack exactly on the 8th cycle -> normal completion with m_dato captured, tout_err stays 0.
- Reset mid-op: rst=1 during GNT_B, then m_ack arrives -> all outputs 0, no b_ack, state IDLE; the next contention is granted to A.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter sharing one external memory controller between a
// CPU-side requester (port A) and a DMA requester (port B).
//
// Each access is a req/ack handshake. Only one port owns the memory at a time.
// When both ports request together, the port that was not served last wins.
// A watchdog forces completion if the memory never answers.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   a_req/a_we/a_addr/a_dati -> a_ack (1-cycle pulse), a_dato (held)   port A
//   b_req/b_we/b_addr/b_dati -> b_ack (1-cycle pulse), b_dato (held)   port B
//   m_req/m_we/m_addr/m_dati -> memory; m_dato/m_ack <- memory
//   grant              bit0 = A owns memory, bit1 = B owns memory
//   tout_err           sticky flag: a transaction was ended by the watchdog
module mem_arb #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int TOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_dati,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_dato,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_dati,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_dato,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dati,
  input  logic [DATA_W-1:0] m_dato,
  input  logic              m_ack,
  output logic [1:0]        grant,
  output logic              tout_err
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, DONE} state_t;

  localparam logic [15:0] TOUT_C = 16'(TOUT);

  state_t              state_q, state_d;
  logic                last_b_q, last_b_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_dati_q, m_dati_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_dato_q, a_dato_d;
  logic [DATA_W-1:0]   b_dato_q, b_dato_d;
  logic [1:0]          grant_q, grant_d;
  logic                tout_err_q, tout_err_d;

  logic                is_b;
  logic                tmo;
  logic [DATA_W-1:0]   rd_val;

  // cnt_q counts completed grant cycles; the TOUT-th grant cycle is the last.
  assign is_b = (state_q == GNT_B);
  assign tmo  = (cnt_q >= (TOUT_C - 16'd1));

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    cnt_d      = cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_dati_d   = m_dati_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_dato_d   = a_dato_q;
    b_dato_d   = b_dato_q;
    grant_d    = grant_q;
    tout_err_d = tout_err_q;
    rd_val     = '0;

    unique case (state_q)
      IDLE: begin
        // A wins if it is alone, or on contention when B was served last.
        if (a_req && (!b_req || last_b_q)) begin
          state_d  = GNT_A;
          m_req_d  = 1'b1;
          m_we_d   = a_we;
          m_addr_d = a_addr;
          m_dati_d = a_dati;
          grant_d  = 2'b01;
          cnt_d    = '0;
        end else if (b_req) begin
          state_d  = GNT_B;
          m_req_d  = 1'b1;
          m_we_d   = b_we;
          m_addr_d = b_addr;
          m_dati_d = b_dati;
          grant_d  = 2'b10;
          cnt_d    = '0;
        end
      end

      GNT_A, GNT_B: begin
        if (m_ack || tmo) begin
          // A real ack beats a coincident timeout.
          rd_val   = m_ack ? m_dato : '1;
          state_d  = DONE;
          m_req_d  = 1'b0;
          grant_d  = 2'b00;
          last_b_d = is_b;
          if (!m_ack) tout_err_d = 1'b1;
          if (is_b) begin
            b_ack_d = 1'b1;
            if (!m_we_q) b_dato_d = rd_val;
          end else begin
            a_ack_d = 1'b1;
            if (!m_we_q) a_dato_d = rd_val;
          end
        end else if (cnt_q != TOUT_C) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      cnt_q      <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_dati_q   <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_dato_q   <= '0;
      b_dato_q   <= '0;
      grant_q    <= 2'b00;
      tout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_dati_q   <= m_dati_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_dato_q   <= a_dato_d;
      b_dato_q   <= b_dato_d;
      grant_q    <= grant_d;
      tout_err_q <= tout_err_d;
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_dato   = a_dato_q;
  assign b_dato   = b_dato_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_dati   = m_dati_q;
  assign grant    = grant_q;
  assign tout_err = tout_err_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb (ADDR_W=23, DATA_W=16, TOUT=8).
module tb_mem_arb;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_we, b_req, b_we, m_ack;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_dati, b_dati, m_dato;
  logic              a_ack, b_ack, m_req, m_we, tout_err;
  logic [DATA_W-1:0] a_dato, b_dato, m_dati;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        grant;

  int ntests = 0;
  int nfail  = 0;

  mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TOUT(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_dati(a_dati),
    .a_ack(a_ack), .a_dato(a_dato),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_dati(b_dati),
    .b_ack(b_ack), .b_dato(b_dato),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_dati(m_dati),
    .m_dato(m_dato), .m_ack(m_ack),
    .grant(grant), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_dati = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_dati = '0;
    m_ack = 0; m_dato = '0;
    step(); step();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tout",  32'(tout_err), 32'd0);
    chk("rst_adato", 32'(a_dato), 32'd0);
    chk("rst_maddr", 32'(m_addr), 32'd0);
    rst = 1'b0;

    // Single read on A, memory acks 3 cycles after m_req.
    a_req = 1; a_we = 0; a_addr = 23'h000123;
    step();
    chk("rdA_m_req", 32'(m_req), 32'd1);
    chk("rdA_maddr", 32'(m_addr), 32'h000123);
    chk("rdA_grant", 32'(grant), 32'd1);
    chk("rdA_mwe",   32'(m_we), 32'd0);
    step(); step();
    chk("rdA_hold",  32'(m_req), 32'd1);
    chk("rdA_noack", 32'(a_ack), 32'd0);
    m_ack = 1; m_dato = 16'hBEEF;
    step();
    chk("rdA_ack",   32'(a_ack), 32'd1);
    chk("rdA_dato",  32'(a_dato), 32'hBEEF);
    chk("rdA_mreq0", 32'(m_req), 32'd0);
    chk("rdA_gnt0",  32'(grant), 32'd0);
    chk("rdA_back",  32'(b_ack), 32'd0);
    m_ack = 0; a_req = 0;
    step();
    chk("rdA_pulse", 32'(a_ack), 32'd0);
    chk("rdA_dhold", 32'(a_dato), 32'hBEEF);
    step();

    // Write on B; inputs changed mid-grant must not leak through.
    b_req = 1; b_we = 1; b_addr = 23'h7FFFFF; b_dati = 16'h55AA;
    step();
    chk("wrB_grant", 32'(grant), 32'd2);
    chk("wrB_mwe",   32'(m_we), 32'd1);
    b_addr = '0; b_dati = 16'h0000; b_we = 0;
    step();
    chk("wrB_maddr", 32'(m_addr), 32'h7FFFFF);
    chk("wrB_mdati", 32'(m_dati), 32'h55AA);
    chk("wrB_mwe2",  32'(m_we), 32'd1);
    m_ack = 1; m_dato = 16'h1234;
    step();
    chk("wrB_ack",   32'(b_ack), 32'd1);
    chk("wrB_dato",  32'(b_dato), 32'h0000);
    chk("wrB_aack",  32'(a_ack), 32'd0);
    m_ack = 0; b_req = 0;
    step(); step();

    // Contention: both hold req high; grants must alternate A,B,A,B.
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      chk($sformatf("cont%0d_grant", i), 32'(grant), 32'(exp_g));
      chk($sformatf("cont%0d_mreq", i), 32'(m_req), 32'd1);
      m_ack = 1; m_dato = 16'hA000 + 16'(i);
      step();
      chk($sformatf("cont%0d_ack", i), 32'({b_ack, a_ack}), 32'(exp_g));
      if (i % 2 == 0) chk($sformatf("cont%0d_dato", i), 32'(a_dato), 32'hA000 + 32'(i));
      else            chk($sformatf("cont%0d_dato", i), 32'(b_dato), 32'hA000 + 32'(i));
      m_ack = 0;
      step();
      chk($sformatf("cont%0d_gap", i), 32'(m_req), 32'd0);
      chk($sformatf("cont%0d_gapg", i), 32'(grant), 32'd0);
    end
    a_req = 0; b_req = 0;
    step();

    // Timeout: A read, memory never acks.
    a_req = 1; a_addr = 23'h000010;
    step();
    chk("to_mreq1", 32'(m_req), 32'd1);
    for (int k = 0; k < 7; k++) step();
    chk("to_mreq8", 32'(m_req), 32'd1);
    chk("to_noerr", 32'(tout_err), 32'd0);
    step();
    chk("to_mreq0", 32'(m_req), 32'd0);
    chk("to_ack",   32'(a_ack), 32'd1);
    chk("to_dato",  32'(a_dato), 32'hFFFF);
    chk("to_err",   32'(tout_err), 32'd1);
    a_req = 0;
    step(); step();
    chk("to_sticky", 32'(tout_err), 32'd1);
    b_req = 1; b_we = 0; b_addr = 23'h000020;
    step();
    chk("to_nextB_grant", 32'(grant), 32'd2);
    m_ack = 1; m_dato = 16'h4321;
    step();
    chk("to_nextB_ack",  32'(b_ack), 32'd1);
    chk("to_nextB_dato", 32'(b_dato), 32'h4321);
    chk("to_sticky2",    32'(tout_err), 32'd1);
    m_ack = 0; b_req = 0;
    step(); step();

    // Ack exactly on the 8th grant cycle beats the timeout.
    rst = 1;
    step();
    rst = 0;
    chk("rst2_tout", 32'(tout_err), 32'd0);
    a_req = 1; a_addr = 23'h000030;
    step();
    for (int k = 0; k < 7; k++) step();
    chk("race_mreq", 32'(m_req), 32'd1);
    m_ack = 1; m_dato = 16'hCAFE;
    step();
    chk("race_ack",  32'(a_ack), 32'd1);
    chk("race_dato", 32'(a_dato), 32'hCAFE);
    chk("race_err",  32'(tout_err), 32'd0);
    m_ack = 0; a_req = 0;
    step(); step();

    // Reset mid-transaction on B; late m_ack is ignored.
    b_req = 1; b_addr = 23'h000040;
    step();
    chk("rmid_grant", 32'(grant), 32'd2);
    rst = 1;
    step();
    chk("rmid_mreq",  32'(m_req), 32'd0);
    chk("rmid_grant0", 32'(grant), 32'd0);
    chk("rmid_bdato", 32'(b_dato), 32'd0);
    rst = 0; b_req = 0; m_ack = 1; m_dato = 16'h9999;
    step();
    chk("rmid_noback", 32'(b_ack), 32'd0);
    chk("rmid_bdato2", 32'(b_dato), 32'd0);
    chk("rmid_mreq2",  32'(m_req), 32'd0);
    m_ack = 0;
    step();
    a_req = 1; b_req = 1;
    step();
    chk("rmid_contA", 32'(grant), 32'd1);
    m_ack = 1; m_dato = 16'h0F0F;
    step();
    chk("rmid_ackA", 32'(a_ack), 32'd1);
    m_ack = 0; a_req = 0; b_req = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
